// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one serial-parallel Multiplier among NREQ requesters.
// Optional feature: define MULT_ZERO_BYPASS_EN to answer zero-operand requests without the Multiplier.
module mult_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 32,
    parameter int START_HLD = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] mp_in,
    input  logic [NREQ*W-1:0] mc_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_err,
    output logic [2*W-1:0]    rsp_prod,
    output logic              busy,
    output logic [W-1:0]      mul_mp,
    output logic [W-1:0]      mul_mc,
    output logic              mul_start,
    input  logic [2*W-1:0]    mul_p,
    input  logic              mul_done
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (TIMEOUT > START_HLD) ? TIMEOUT : START_HLD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [PW-1:0]     ptr, ptr_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [NREQ-1:0]   gnt_d, rsp_valid_d;
    logic              rsp_err_d, mul_start_d;
    logic [2*W-1:0]    rsp_prod_d;
    logic [W-1:0]      mul_mp_d, mul_mc_d;

    logic              found;
    logic [PW-1:0]     win, scan_idx;
    int                scan_int;
    logic [NREQ-1:0]   win_oh;
    logic [W-1:0]      win_mp, win_mc;

    // Round-robin scan: first requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        found    = 1'b0;
        win      = ptr;
        scan_int = 0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_int = int'(ptr) + k;
            if (scan_int >= NREQ) scan_int = scan_int - NREQ;
            scan_idx = PW'(scan_int);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    assign win_oh = NREQ'(1) << win;
    assign win_mp = mp_in[int'(win)*W +: W];
    assign win_mc = mc_in[int'(win)*W +: W];
    assign busy   = (state != IDLE);

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = cnt;
        gnt_d       = gnt;
        mul_mp_d    = mul_mp;
        mul_mc_d    = mul_mc;
        mul_start_d = mul_start;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_prod_d  = rsp_prod;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_d    = win_oh;
                    mul_mp_d = win_mp;
                    mul_mc_d = win_mc;
                    ptr_d    = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
                    cnt_d    = '0;
`ifdef MULT_ZERO_BYPASS_EN
                    if (win_mp == '0 || win_mc == '0) begin
                        rsp_valid_d = win_oh;
                        rsp_prod_d  = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        mul_start_d = 1'b1;
                        state_d     = START;
                    end
`else
                    mul_start_d = 1'b1;
                    state_d     = START;
`endif
                end
            end
            START: begin
                // cnt counts start cycles already spent high; the last one drops start.
                if (cnt == CW'(START_HLD-1)) begin
                    mul_start_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (mul_done) begin
                    rsp_prod_d  = mul_p;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = gnt;
                    state_d     = RESP;
                end else if (cnt == CW'(TIMEOUT)) begin
                    rsp_prod_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = gnt;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                gnt_d       = '0;
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            mul_mp    <= '0;
            mul_mc    <= '0;
            mul_start <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_prod  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            mul_mp    <= mul_mp_d;
            mul_mc    <= mul_mc_d;
            mul_start <= mul_start_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_prod  <= rsp_prod_d;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural serial Multiplier and a response scoreboard.
// Expectations follow MULT_ZERO_BYPASS_EN when the bench is built with it defined.
module tb_mult_share_arbiter;

    localparam int NREQ      = 4;
    localparam int W         = 32;
    localparam int START_HLD = 4;
    localparam int TIMEOUT   = 255;
    localparam int LAT       = W + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] mp_in, mc_in;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic              rsp_err, busy, mul_start, mul_done;
    logic [2*W-1:0]    rsp_prod, mul_p;
    logic [W-1:0]      mul_mp, mul_mc;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NREQ(NREQ), .W(W), .START_HLD(START_HLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mp_in(mp_in), .mc_in(mc_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_prod(rsp_prod),
        .busy(busy), .mul_mp(mul_mp), .mul_mc(mul_mc), .mul_start(mul_start),
        .mul_p(mul_p), .mul_done(mul_done)
    );

    // Behavioural Multiplier: done cleared on start, product ready LAT cycles after start falls.
    logic        stuck;
    int          mcnt;
    logic [W-1:0] m_a, m_b;
    always @(posedge clk) begin
        if (rst) begin
            mul_done <= 1'b0;
            mcnt     <= 0;
            mul_p    <= '0;
        end else if (mul_start) begin
            mul_done <= 1'b0;
            mcnt     <= LAT;
            m_a      <= mul_mp;
            m_b      <= mul_mc;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !stuck) begin
                mul_done <= 1'b1;
                mul_p    <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
            end
        end
    end

    typedef struct {
        int             idx;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    int   st_run   = 0;
    int   start_total = 0;
    int   wc       = 0;
    int   last_lat = 0;

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic push(input int idx, input logic [2*W-1:0] prod, input logic err);
        exp_t t;
        t.idx  = idx;
        t.prod = prod;
        t.err  = err;
        sb.push_back(t);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        mp_in[i*W +: W] = a;
        mc_in[i*W +: W] = b;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int cyc = 0;
        while (n_rsp < target && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
        end
        last_lat = cyc;
        if (n_rsp < target) check("rsp_timeout", 64'(n_rsp), 64'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},       64'(gnt),       64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        check({tag, "_mul_mp"},    64'(mul_mp),    64'd0);
        check({tag, "_mul_mc"},    64'(mul_mc),    64'd0);
        check({tag, "_rsp_prod"},  rsp_prod,       64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    endtask

    // Monitor: one-hot grant, start pulse length, WAIT length and scoreboard pops.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            st_run = 0;
            wc     = 0;
        end else begin
            if (gnt != '0) check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
            if (mul_start) begin
                st_run++;
                start_total++;
                wc = 0;
            end else begin
                if (st_run != 0) begin
                    check("start_len", 64'(st_run), 64'(START_HLD));
                    st_run = 0;
                end
                if (busy && rsp_valid == '0) wc++;
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
                    check("rsp_prod", rsp_prod, e.prod);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.err) check("timeout_len", 64'(wc >= TIMEOUT && wc <= TIMEOUT + 1), 64'd1);
                end
                n_rsp++;
            end
        end
    end

    initial begin
        int cyc;
        int s0;
        rst   = 1'b1;
        req   = '0;
        mp_in = '0;
        mc_in = '0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single request 15*7.
        set_op(0, 32'd15, 32'd7);
        push(0, 64'd105, 1'b0);
        req = 4'b0001;
        @(negedge clk); #1;
        check("t1_gnt", 64'(gnt), 64'b0001);
        check("t1_busy", 64'(busy), 64'd1);
        wait_rsp(n_rsp + 1, 200);
        req = '0;
        @(negedge clk); #1;
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_gnt_after", 64'(gnt), 64'd0);

        // All four requesting from ptr=0: order 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 2), W'(i + 3));
        push(0, 64'd6, 1'b0);
        push(1, 64'd12, 1'b0);
        push(2, 64'd20, 1'b0);
        push(3, 64'd30, 1'b0);
        push(0, 64'd6, 1'b0);
        req = 4'b1111;
        wait_rsp(n_rsp + 5, 600);
        req = '0;

        // Full-width operands.
        set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(2, 64'hFFFF_FFFE_0000_0001, 1'b0);
        req = 4'b0100;
        wait_rsp(n_rsp + 1, 200);
        req = '0;

        // Multiplier never answers: watchdog abort, then normal service.
        stuck = 1'b1;
        set_op(1, 32'd3, 32'd5);
        push(1, 64'd0, 1'b1);
        req = 4'b0010;
        wait_rsp(n_rsp + 1, 400);
        req   = '0;
        stuck = 1'b0;
        set_op(3, 32'd11, 32'd13);
        push(3, 64'd143, 1'b0);
        req = 4'b1000;
        wait_rsp(n_rsp + 1, 200);
        req = '0;

        // Reset pulse in the middle of WAIT.
        set_op(2, 32'd100, 32'd200);
        req = 4'b0100;
        cyc = 0;
        while (!mul_start && cyc < 50) begin @(negedge clk); #1; cyc++; end
        check("t5_start_seen", 64'(mul_start), 64'd1);
        while (mul_start && cyc < 50) begin @(negedge clk); #1; cyc++; end
        repeat (5) @(negedge clk);
        #1;
        check("t5_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk); #1;
        rst = 1'b0;
        check_all_zero("mid_rst");
        set_op(1, 32'd7, 32'd8);
        set_op(3, 32'h1234_5678, 32'h9ABC_DEF0);
        push(1, mul_ref(32'd7, 32'd8), 1'b0);
        push(3, mul_ref(32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
        req = 4'b1010;
        wait_rsp(n_rsp + 1, 200);
        req[1] = 1'b0;
        wait_rsp(n_rsp + 1, 200);
        req[3] = 1'b0;

        // Zero operand.
        set_op(0, 32'd0, 32'd9);
        s0 = start_total;
        push(0, 64'd0, 1'b0);
        req = 4'b0001;
        wait_rsp(n_rsp + 1, 200);
        req = '0;
`ifdef MULT_ZERO_BYPASS_EN
        check("t6_start_cycles", 64'(start_total - s0), 64'd0);
        check("t6_fast", 64'(last_lat <= 2), 64'd1);
`else
        check("t6_start_cycles", 64'(start_total - s0), 64'(START_HLD));
`endif

        repeat (5) @(negedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
